// File: rtl/sirv_regvec_sync_reader_pkg.sv
// Shared definitions for the AON register-vector reader: read FSM state encoding
// and default parameter values.
package sirv_regvec_defines;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } rd_state_e;

  localparam int DEF_DW          = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CNT  = 4;

endpackage

// File: rtl/sirv_regvec_sync_reader_if.sv
// 4-phase req/ack read port of the register-vector reader.
interface sirv_regvec_sync_reader_if #(
  parameter int DW = 3
);
  logic          i_rd_req;
  logic          o_rd_ack;
  logic [DW-1:0] o_rd_data;

  modport master (output i_rd_req, input o_rd_ack, input o_rd_data);
  modport slave  (input i_rd_req, output o_rd_ack, output o_rd_data);
endinterface

// File: rtl/sirv_regvec_sync_reader_sync_stage.sv
// DW-wide, SYNC_STAGES-deep flop synchronizer with asynchronous active-low reset.
module sirv_regvec_sync_stage #(
  parameter int                DW          = 3,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DW-1:0]     RST_VAL     = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sirv_regvec_sync_reader.sv
// Synchronizes and stability-filters a foreign-domain vector and serves it over a
// 4-phase read port. Optional sticky change flag: SIRV_REGVEC_CHG_STICKY_EN.
//
// state   | meaning
// IDLE    | no read in progress
// WAIT    | request seen, waiting for a settled value
// ACK     | o_rd_data captured, acknowledge held until request drops
module sirv_regvec_sync_reader
  import sirv_regvec_defines::*;
#(
  parameter int            DW          = DEF_DW,
  parameter int            SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int            STABLE_CNT  = DEF_STABLE_CNT,
  parameter logic [DW-1:0] RST_VAL     = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DW-1:0]                 i_vec,
  sirv_regvec_sync_reader_if.slave      rd,
  output logic [DW-1:0]                 o_q,
  output logic                          o_chg
`ifdef SIRV_REGVEC_CHG_STICKY_EN
  ,
  input  logic                          i_chg_clr,
  output logic                          o_chg_sticky
`endif
);

  localparam int             CW      = $clog2(STABLE_CNT) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT - 1);

  logic [DW-1:0] sync_v;
  logic [DW-1:0] cand;
  logic [DW-1:0] q_next;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rd_data;
  logic          settled;
  rd_state_e     state;

  sirv_regvec_sync_stage #(
    .DW          (DW),
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (RST_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_vec),
    .q     (sync_v)
  );

  // o_q loads on the edge that observes the STABLE_CNT-th consecutive equal sample.
  always_comb begin
    q_next = o_q;
    if (sync_v != cand) begin
      if (STABLE_CNT == 1) q_next = sync_v;
    end else if ((cnt == CNT_MAX) || (cnt + 1'b1 == CNT_MAX)) begin
      q_next = cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand  <= RST_VAL;
      cnt   <= '0;
      o_q   <= RST_VAL;
      o_chg <= 1'b0;
    end else begin
      if (sync_v != cand) begin
        cand <= sync_v;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      o_q   <= q_next;
      o_chg <= (q_next != o_q);
    end
  end

  // When settled no o_q update is pending, so the captured value cannot be stale.
  assign settled = (cnt == CNT_MAX) && (sync_v == cand) && (cand == o_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rd_data <= RST_VAL;
    end else begin
      case (state)
        ST_IDLE: if (rd.i_rd_req) state <= ST_WAIT;
        ST_WAIT: begin
          if (!rd.i_rd_req) begin
            state <= ST_IDLE;
          end else if (settled) begin
            state   <= ST_ACK;
            rd_data <= o_q;
          end
        end
        ST_ACK:  if (!rd.i_rd_req) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rd.o_rd_ack  = (state == ST_ACK);
  assign rd.o_rd_data = rd_data;

`ifdef SIRV_REGVEC_CHG_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         o_chg_sticky <= 1'b0;
    else if (o_chg)     o_chg_sticky <= 1'b1;
    else if (i_chg_clr) o_chg_sticky <= 1'b0;
  end
`endif

endmodule
